dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-port arbiter/sequencer in front of the single-ported data memory.
//  Port 0 is the CPU load/store stage; port 1 is a secondary master (program loader / debug).
//  Fair round-robin between ports, valid/ready handshake per port.
//  Each accepted request runs as one memory access cycle followed by a registered response.
//  Misaligned and reserved-size requests return an error and never reach memory.
// PARAMETERS
//  WIDTH  32  data and address width; size encoding matches memory: 00 word, 01 half, 10 byte
// PORTS
//  clk          in   1      single clock, all state on posedge
//  rst          in   1      synchronous, active-high reset
//  req0_valid   in   1      port 0 request present
//  req0_ready   out  1      port 0 request accepted this cycle
//  req0_write   in   1      1 = store, 0 = load
//  req0_size    in   2      00 word / 01 half / 10 byte / 11 reserved
//  req0_sign    in   1      load extension: 1 sign, 0 zero (passed to memory)
//  req0_addr    in   WIDTH  byte address
//  req0_wdata   in   WIDTH  store data
//  rsp0_valid   out  1      one-cycle response pulse for port 0
//  rsp0_err     out  1      response is an error (misaligned / reserved size)
//  rsp0_rdata   out  WIDTH  load data (0 for stores and errors)
//  req1_* / rsp1_*  same set and widths as port 0, for port 1
//  mem_we       out  1      memory write enable
//  mem_size     out  2      to memory LoadSrc
//  mem_sign     out  1      to memory LoadSign
//  mem_addr     out  WIDTH  to memory address
//  mem_wdata    out  WIDTH  to memory WriteData
//  mem_rdata    in   WIDTH  memory read data (combinational, already extended)
//  grant_id     out  1      port owning the current/last access
// BEHAVIOUR
//  - FSM: IDLE -> ACCESS -> IDLE. ready is asserted only in IDLE, so at most one request is in flight.
//  - Grant in IDLE (combinational):
//    - only one valid: that port wins.
//    - both valid: the port != last_grant wins.
//    - readyN = IDLE & grant==N & reqN_valid.
//  - On accept edge: capture write/size/sign/addr/wdata/port, update last_grant, go to ACCESS.
//    - err = size==11 | (size==01 & addr[0]) | (size==00 & addr[1:0]!=0).
//  - Requester holds all req signals stable while valid & !ready; dropping valid unaccepted is legal.
//  - ACCESS (exactly 1 cycle): mem_* driven from the capture register.
//    - mem_we = write & !err, for this cycle only.
//    - End of ACCESS edge: rdata_reg <= (read & !err) ? mem_rdata : 0. Return to IDLE.
//  - Response cycle (first IDLE cycle after ACCESS):
//    - rspN_valid=1 for the captured port only; rspN_err / rspN_rdata valid with it.
//    - Other port's rsp outputs stay 0.
//    - A new request may be accepted in this same cycle.
//  - Latency: accept edge + 2 edges to rsp_valid. Throughput: 1 access per 2 cycles.
//  - Sustained contention: grants strictly alternate 0,1,0,1.
//  - Outside ACCESS: mem_we=0; mem_size/sign/addr/wdata hold the last captured values.
//  - Arbiter applies no data extension or lane shifting; memory owns those.
//  - Reset:
//    - state IDLE; last_grant=1 (port 0 wins first tie); grant_id=0.
//    - All outputs 0, including capture regs, so mem_* = 0.
//    - rst high at any edge, including mid-ACCESS: the next cycle is IDLE with mem_we=0 and
//      no response for the aborted request. A store aborted by rst in ACCESS was already
//      written during that ACCESS cycle (write commits at that edge).
// TESTING
//  1. Reset, hold both valid low -> all outputs 0; req0_valid=1 -> req0_ready=1 same cycle.
//  2. Port 0 sw addr 0x10, wdata 0xDEADBEEF -> next cycle mem_we=1, mem_addr=0x10, mem_size=00;
//     then rsp0_valid=1, rsp0_err=0, rsp0_rdata=0.
//  3. Both ports lw continuously -> accepts alternate 0,1,0,1 two cycles apart; rsp pulses to matching port only.
//  4. Port 1 lh addr 0x3 -> mem_we never asserted; rsp1_valid=1, rsp1_err=1, rsp1_rdata=0. Size 11 gives the same result.
//  5. Port 0 lh signed addr 0x4, mem_rdata=0xFFFF8001 in ACCESS -> rsp0_rdata=0xFFFF8001, rsp0_err=0.
//  6. rst asserted during ACCESS of a port 1 load -> next cycle IDLE, mem_we=0, no rsp1_valid; a port 0 request waiting through the tie wins first after reset.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-ported data memory.
interface dmem_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic             req0_write;
    logic [1:0]       req0_size;
    logic             req0_sign;
    logic [WIDTH-1:0] req0_addr;
    logic [WIDTH-1:0] req0_wdata;
    logic             rsp0_valid;
    logic             rsp0_err;
    logic [WIDTH-1:0] rsp0_rdata;

    logic             req1_valid;
    logic             req1_ready;
    logic             req1_write;
    logic [1:0]       req1_size;
    logic             req1_sign;
    logic [WIDTH-1:0] req1_addr;
    logic [WIDTH-1:0] req1_wdata;
    logic             rsp1_valid;
    logic             rsp1_err;
    logic [WIDTH-1:0] rsp1_rdata;

    logic             mem_we;
    logic [1:0]       mem_size;
    logic             mem_sign;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             grant_id;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_write, req0_size, req0_sign, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_size, req1_sign, req1_addr, req1_wdata,
        input  mem_rdata,
        output req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_err, rsp1_rdata,
        output mem_we, mem_size, mem_sign, mem_addr, mem_wdata, grant_id
    );

    // Requester / memory side.
    modport master (
        output req0_valid, req0_write, req0_size, req0_sign, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_size, req1_sign, req1_addr, req1_wdata,
        output mem_rdata,
        input  req0_ready, rsp0_valid, rsp0_err, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_err, rsp1_rdata,
        input  mem_we, mem_size, mem_sign, mem_addr, mem_wdata, grant_id
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single-ported data memory.
module dmem_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input logic            clk,
    input logic            rst,
    dmem_arbiter_if.slave  bus
);
    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t           state;
    logic             last_grant;
    logic             grant;
    logic             accept;

    logic             sel_write;
    logic             sel_sign;
    logic             sel_err;
    logic [1:0]       sel_size;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wdata;

    logic             cap_write;
    logic             cap_sign;
    logic             cap_err;
    logic             cap_port;
    logic [1:0]       cap_size;
    logic [WIDTH-1:0] cap_addr;
    logic [WIDTH-1:0] cap_wdata;

    logic             mem_we_q;
    logic             grant_id_q;
    logic             rsp0_valid_q;
    logic             rsp0_err_q;
    logic [WIDTH-1:0] rsp0_rdata_q;
    logic             rsp1_valid_q;
    logic             rsp1_err_q;
    logic [WIDTH-1:0] rsp1_rdata_q;

    // Round-robin pick, selected request fields and alignment check.
    // Acceptance is held off while rst is high so no requester sees a handshake that is discarded.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
        accept    = (state == IDLE) && !rst && (grant ? bus.req1_valid : bus.req0_valid);
        sel_write = grant ? bus.req1_write : bus.req0_write;
        sel_sign  = grant ? bus.req1_sign  : bus.req0_sign;
        sel_size  = grant ? bus.req1_size  : bus.req0_size;
        sel_addr  = grant ? bus.req1_addr  : bus.req0_addr;
        sel_wdata = grant ? bus.req1_wdata : bus.req0_wdata;
        sel_err   = (sel_size == SIZE_RSVD)
                  || ((sel_size == SIZE_HALF) && sel_addr[0])
                  || ((sel_size == SIZE_WORD) && (sel_addr[1:0] != 2'b00));
    end

    assign bus.req0_ready = accept && !grant;
    assign bus.req1_ready = accept && grant;

    // Sequencer: capture on accept, one memory cycle, then a one-cycle registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant_id_q   <= 1'b0;
            cap_write    <= 1'b0;
            cap_sign     <= 1'b0;
            cap_err      <= 1'b0;
            cap_port     <= 1'b0;
            cap_size     <= 2'b00;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            mem_we_q     <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp0_err_q   <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_valid_q <= 1'b0;
            rsp1_err_q   <= 1'b0;
            rsp1_rdata_q <= '0;
        end else begin
            mem_we_q     <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp0_err_q   <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_valid_q <= 1'b0;
            rsp1_err_q   <= 1'b0;
            rsp1_rdata_q <= '0;
            if (state == IDLE) begin
                if (accept) begin
                    cap_write  <= sel_write;
                    cap_sign   <= sel_sign;
                    cap_size   <= sel_size;
                    cap_addr   <= sel_addr;
                    cap_wdata  <= sel_wdata;
                    cap_err    <= sel_err;
                    cap_port   <= grant;
                    last_grant <= grant;
                    grant_id_q <= grant;
                    mem_we_q   <= sel_write && !sel_err;
                    state      <= ACCESS;
                end
            end else begin
                if (cap_port) begin
                    rsp1_valid_q <= 1'b1;
                    rsp1_err_q   <= cap_err;
                    rsp1_rdata_q <= (!cap_write && !cap_err) ? bus.mem_rdata : '0;
                end else begin
                    rsp0_valid_q <= 1'b1;
                    rsp0_err_q   <= cap_err;
                    rsp0_rdata_q <= (!cap_write && !cap_err) ? bus.mem_rdata : '0;
                end
                state <= IDLE;
            end
        end
    end

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_size   = cap_size;
    assign bus.mem_sign   = cap_sign;
    assign bus.mem_addr   = cap_addr;
    assign bus.mem_wdata  = cap_wdata;
    assign bus.grant_id   = grant_id_q;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp0_err   = rsp0_err_q;
    assign bus.rsp0_rdata = rsp0_rdata_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp1_err   = rsp1_err_q;
    assign bus.rsp1_rdata = rsp1_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, store, contention, errors, signed load, reset abort.
module tb_dmem_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic        ovr_en;
    logic [31:0] ovr_val;
    logic        g;
    logic        prev;

    dmem_arbiter_if #(.WIDTH(32)) bus ();

    dmem_arbiter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory stand-in: read data is address + 0x1000 unless a step overrides it.
    assign bus.mem_rdata = ovr_en ? ovr_val : (bus.mem_addr + 32'h0000_1000);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        ovr_en  = 1'b0;
        ovr_val = 32'h0;
        rst     = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_size = 2'b00;
        bus.req0_sign  = 1'b0; bus.req0_addr  = 32'h0; bus.req0_wdata = 32'h0;
        bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_size = 2'b00;
        bus.req1_sign  = 1'b0; bus.req1_addr  = 32'h0; bus.req1_wdata = 32'h0;

        // Test 1: reset state
        next(); next();
        rst = 1'b0;
        mid();
        check("rst_mem_we",   32'(bus.mem_we), 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_size", 32'(bus.mem_size), 32'h0);
        check("rst_rsp0",     32'(bus.rsp0_valid), 32'h0);
        check("rst_rsp1",     32'(bus.rsp1_valid), 32'h0);
        check("rst_grant_id", 32'(bus.grant_id), 32'h0);
        check("rst_ready0",   32'(bus.req0_ready), 32'h0);
        #1;
        bus.req0_valid = 1'b1; bus.req0_write = 1'b1; bus.req0_size = 2'b00;
        bus.req0_addr = 32'h10; bus.req0_wdata = 32'hDEAD_BEEF;
        #1;
        check("t1_ready0_same_cycle", 32'(bus.req0_ready), 32'h1);
        check("t1_ready1",            32'(bus.req1_ready), 32'h0);

        // Test 2: port 0 store
        next();
        bus.req0_valid = 1'b0;
        mid();
        check("t2_mem_we",    32'(bus.mem_we), 32'h1);
        check("t2_mem_addr",  bus.mem_addr, 32'h10);
        check("t2_mem_size",  32'(bus.mem_size), 32'h0);
        check("t2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        check("t2_grant_id",  32'(bus.grant_id), 32'h0);
        next(); mid();
        check("t2_rsp0_valid", 32'(bus.rsp0_valid), 32'h1);
        check("t2_rsp0_err",   32'(bus.rsp0_err), 32'h0);
        check("t2_rsp0_rdata", bus.rsp0_rdata, 32'h0);
        check("t2_rsp1_valid", 32'(bus.rsp1_valid), 32'h0);
        check("t2_mem_we_off", 32'(bus.mem_we), 32'h0);
        check("t2_addr_hold",  bus.mem_addr, 32'h10);

        // Test 3: both ports loading continuously; last grant was 0, so port 1 wins first
        next();
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_size = 2'b00; bus.req0_addr = 32'h20;
        bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_size = 2'b00; bus.req1_addr = 32'h40;
        mid();
        g = 1'b1;
        prev = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t3_ready_win",  32'(g ? bus.req1_ready : bus.req0_ready), 32'h1);
            check("t3_ready_lose", 32'(g ? bus.req0_ready : bus.req1_ready), 32'h0);
            if (k > 0) begin
                check("t3_rsp_owner", 32'(prev ? bus.rsp1_valid : bus.rsp0_valid), 32'h1);
                check("t3_rsp_other", 32'(prev ? bus.rsp0_valid : bus.rsp1_valid), 32'h0);
                check("t3_rsp_rdata", prev ? bus.rsp1_rdata : bus.rsp0_rdata,
                      prev ? 32'h0000_1040 : 32'h0000_1020);
            end
            next();
            if (k == 3) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            mid();
            check("t3_grant_id", 32'(bus.grant_id), 32'(g));
            check("t3_mem_addr", bus.mem_addr, g ? 32'h40 : 32'h20);
            check("t3_mem_we",   32'(bus.mem_we), 32'h0);
            next(); mid();
            prev = g;
            g = ~g;
        end
        check("t3_last_rsp0",  32'(bus.rsp0_valid), 32'h1);
        check("t3_last_rsp1",  32'(bus.rsp1_valid), 32'h0);
        check("t3_last_rdata", bus.rsp0_rdata, 32'h0000_1020);

        // Test 4: port 1 misaligned half load, then reserved-size store
        next();
        bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_size = 2'b01; bus.req1_addr = 32'h3;
        mid();
        check("t4_ready1", 32'(bus.req1_ready), 32'h1);
        next();
        bus.req1_valid = 1'b0;
        mid();
        check("t4_mem_we", 32'(bus.mem_we), 32'h0);
        next(); mid();
        check("t4_rsp1_valid", 32'(bus.rsp1_valid), 32'h1);
        check("t4_rsp1_err",   32'(bus.rsp1_err), 32'h1);
        check("t4_rsp1_rdata", bus.rsp1_rdata, 32'h0);
        check("t4_rsp0_valid", 32'(bus.rsp0_valid), 32'h0);
        next();
        bus.req1_valid = 1'b1; bus.req1_write = 1'b1; bus.req1_size = 2'b11;
        bus.req1_addr = 32'h8; bus.req1_wdata = 32'h1234_5678;
        mid();
        check("t4b_ready1", 32'(bus.req1_ready), 32'h1);
        next();
        bus.req1_valid = 1'b0;
        mid();
        check("t4b_mem_we", 32'(bus.mem_we), 32'h0);
        next(); mid();
        check("t4b_rsp1_valid", 32'(bus.rsp1_valid), 32'h1);
        check("t4b_rsp1_err",   32'(bus.rsp1_err), 32'h1);
        check("t4b_rsp1_rdata", bus.rsp1_rdata, 32'h0);

        // Test 5: port 0 signed half load, memory returns extended data
        next();
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_size = 2'b01;
        bus.req0_sign = 1'b1; bus.req0_addr = 32'h4;
        ovr_en = 1'b1; ovr_val = 32'hFFFF_8001;
        mid();
        check("t5_ready0", 32'(bus.req0_ready), 32'h1);
        next();
        bus.req0_valid = 1'b0;
        mid();
        check("t5_mem_size", 32'(bus.mem_size), 32'h1);
        check("t5_mem_sign", 32'(bus.mem_sign), 32'h1);
        check("t5_mem_addr", bus.mem_addr, 32'h4);
        check("t5_mem_we",   32'(bus.mem_we), 32'h0);
        next(); mid();
        check("t5_rsp0_valid", 32'(bus.rsp0_valid), 32'h1);
        check("t5_rsp0_err",   32'(bus.rsp0_err), 32'h0);
        check("t5_rsp0_rdata", bus.rsp0_rdata, 32'hFFFF_8001);
        ovr_en = 1'b0;

        // Test 6: reset during a port 1 ACCESS; waiting port 0 wins the tie afterwards
        next();
        bus.req0_sign = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_size = 2'b00; bus.req1_addr = 32'h80;
        mid();
        check("t6_ready1", 32'(bus.req1_ready), 32'h1);
        next();
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_size = 2'b00; bus.req0_addr = 32'h20;
        mid();
        check("t6_access_grant", 32'(bus.grant_id), 32'h1);
        check("t6_rst_ready0",   32'(bus.req0_ready), 32'h0);
        next();
        rst = 1'b0;
        mid();
        check("t6_no_rsp1",   32'(bus.rsp1_valid), 32'h0);
        check("t6_mem_we",    32'(bus.mem_we), 32'h0);
        check("t6_mem_addr",  bus.mem_addr, 32'h0);
        check("t6_grant_id",  32'(bus.grant_id), 32'h0);
        check("t6_ready0",    32'(bus.req0_ready), 32'h1);
        check("t6_ready1",    32'(bus.req1_ready), 32'h0);
        next();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        mid();
        check("t6_post_grant", 32'(bus.grant_id), 32'h0);
        check("t6_post_addr",  bus.mem_addr, 32'h20);
        next(); mid();
        check("t6_rsp0_valid", 32'(bus.rsp0_valid), 32'h1);
        check("t6_rsp0_rdata", bus.rsp0_rdata, 32'h0000_1020);
        check("t6_rsp1_valid", 32'(bus.rsp1_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
